// File: rtl/sdfp_stage_sequencer.sv
// sdfp_stage_sequencer: time-multiplexed cascade of feedback biquad stages for
// the SDFP loop filter. One shared adder/shift datapath evaluates one stage per
// clock for each accepted P/Q bitstream sample.
// Optional build macro: SDFP_SEQ_SAT_EN (saturating arithmetic plus sticky sat_flag).
module sdfp_stage_sequencer #(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned GAIN_K     = 1,
    parameter int unsigned GAIN_TS    = 0,
    parameter int unsigned STG_AW     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_p,
    input  logic                  in_q,
    input  logic                  flush,
    input  logic                  cfg_we,
    input  logic                  cfg_sel,
    input  logic [STG_AW-1:0]     cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  cfg_ready,
    output logic                  out_valid,
    output logic [OUT_WIDTH-1:0]  system_out,
`ifdef SDFP_SEQ_SAT_EN
    output logic                  sat_flag,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [STG_AW-1:0]     stg_q;
    logic                  p_q;
    logic                  q_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] dly_q [NUM_STAGES];
    logic [DATA_WIDTH-1:0] gf_q  [NUM_STAGES];
    logic [DATA_WIDTH-1:0] gb_q  [NUM_STAGES];

    logic                  accept_c;
    logic                  last_c;
    logic [DATA_WIDTH-1:0] gf_sel_c;
    logic [DATA_WIDTH-1:0] gb_sel_c;
    logic [DATA_WIDTH-1:0] dly_sel_c;
    logic [DATA_WIDTH-1:0] y_c;

    // in_ready is a registered copy of "state is IDLE"; the others alias it
    assign cfg_ready = in_ready;
    assign busy      = ~in_ready;
    assign accept_c  = in_valid & in_ready;
    assign last_c    = (stg_q == STG_AW'(NUM_STAGES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c) state_d = S_RUN;
            S_RUN:   if (last_c)   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Select the bank entries for the stage currently being evaluated
    always_comb begin
        gf_sel_c  = '0;
        gb_sel_c  = '0;
        dly_sel_c = '0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            if (stg_q == STG_AW'(i)) begin
                gf_sel_c  = gf_q[i];
                gb_sel_c  = gb_q[i];
                dly_sel_c = dly_q[i];
            end
        end
    end

`ifdef SDFP_SEQ_SAT_EN
    localparam int unsigned FW = DATA_WIDTH + GAIN_K + GAIN_TS + 2;
    localparam logic [FW-1:0] MAX_F = {{(FW - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    logic [FW-1:0] acc_f_c;
    logic [FW-1:0] acc_cl_c;
    logic [FW-1:0] y_f_c;
    logic          sat_c;

    // Full-precision stage math, clamped to the largest DATA_WIDTH value
    always_comb begin
        acc_f_c  = (p_q ? FW'(gf_sel_c) : '0) + (q_q ? FW'(gb_sel_c) : '0)
                 + FW'(prev_q) + FW'(dly_sel_c);
        acc_cl_c = (acc_f_c > MAX_F) ? MAX_F : acc_f_c;
        y_f_c    = acc_cl_c << GAIN_K;
        y_f_c    = y_f_c << GAIN_TS;
        sat_c    = (acc_f_c > MAX_F) | (y_f_c > MAX_F);
        y_c      = (y_f_c > MAX_F) ? {DATA_WIDTH{1'b1}} : DATA_WIDTH'(y_f_c);
    end
`else
    logic [DATA_WIDTH-1:0] acc_c;

    // Modulo-2^DATA_WIDTH stage math
    always_comb begin
        acc_c = (p_q ? gf_sel_c : '0) + (q_q ? gb_sel_c : '0) + prev_q + dly_sel_c;
        y_c   = acc_c << GAIN_K;
        y_c   = y_c << GAIN_TS;
    end
`endif

    // Datapath, register banks and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            system_out <= '0;
            stg_q      <= '0;
            p_q        <= 1'b0;
            q_q        <= 1'b0;
            prev_q     <= '0;
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                dly_q[i] <= '0;
                gf_q[i]  <= DATA_WIDTH'(1);
                gb_q[i]  <= DATA_WIDTH'(1);
            end
`ifdef SDFP_SEQ_SAT_EN
            sat_flag   <= 1'b0;
`endif
        end else begin
            in_ready  <= (state_d == S_IDLE);
            out_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Gain write; addresses beyond the last stage match nothing
                    if (cfg_we) begin
                        for (int i = 0; i < int'(NUM_STAGES); i++) begin
                            if (cfg_addr == STG_AW'(i)) begin
                                if (cfg_sel) gb_q[i] <= cfg_data;
                                else         gf_q[i] <= cfg_data;
                            end
                        end
                    end
                    if (flush) begin
                        for (int i = 0; i < int'(NUM_STAGES); i++) dly_q[i] <= '0;
`ifdef SDFP_SEQ_SAT_EN
                        sat_flag <= 1'b0;
`endif
                    end
                    if (accept_c) begin
                        p_q    <= in_p;
                        q_q    <= in_q;
                        stg_q  <= '0;
                        prev_q <= '0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < int'(NUM_STAGES); i++) begin
                        if (stg_q == STG_AW'(i)) dly_q[i] <= y_c;
                    end
                    prev_q <= y_c;
                    stg_q  <= stg_q + STG_AW'(1);
`ifdef SDFP_SEQ_SAT_EN
                    if (sat_c) sat_flag <= 1'b1;
`endif
                    // Output lands together with the pulse seen in DONE
                    if (last_c) begin
                        out_valid  <= 1'b1;
                        system_out <= OUT_WIDTH'(y_c) + OUT_WIDTH'(p_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sdfp_stage_sequencer.md
Name: sdfp_stage_sequencer

Overview:
Time-multiplexed replacement for a cascade of feedback biquad stages in the SDFP loop filter. A single shared adder/shift datapath evaluates NUM_STAGES stages serially, one stage per clock, for each incoming P/Q bitstream sample. Per-stage delay state and per-stage forward/backward gains are held in register banks. Gains are programmable through a small config port while the block is idle. The block sits between the bitstream front end and the quantiser feedback path.

Parameters:
NUM_STAGES, 3, number of cascaded stages evaluated per sample (2..8)
DATA_WIDTH, 14, stage state/output width; arithmetic is modulo 2^DATA_WIDTH
OUT_WIDTH, 16, system_out width (must be > DATA_WIDTH)
GAIN_K, 1, left-shift amount applied to the stage sum
GAIN_TS, 0, second left-shift amount applied after GAIN_K
STG_AW, 3, config stage-address width (2^STG_AW >= NUM_STAGES)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  sample offered
in_ready  out  1  high when IDLE; sample accepted on in_valid & in_ready
in_p  in  1  forward bitstream bit
in_q  in  1  backward bitstream bit
flush  in  1  clears the delay bank when IDLE
cfg_we  in  1  gain write strobe
cfg_sel  in  1  0 = forward gain, 1 = backward gain
cfg_addr  in  STG_AW  stage index
cfg_data  in  DATA_WIDTH  gain value
cfg_ready  out  1  equals in_ready; writes with cfg_ready low are ignored
out_valid  out  1  one-cycle pulse when system_out is updated
system_out  out  OUT_WIDTH  filter output, held between pulses
busy  out  1  ~in_ready

Behaviour:
- Reset values: in_ready/cfg_ready = 1, busy = 0, out_valid = 0, system_out = 0, all delays = 0, all gains = 1, state = IDLE.
- FSM states:
  - IDLE: on accept, latch in_p/in_q, set stage index s = 0, set prev = 0, go to RUN.
  - RUN: one stage per cycle; after s = NUM_STAGES-1, go to DONE.
  - DONE: out_valid = 1 for this cycle, then return to IDLE.
- Stage s math:
  - acc = (p ? gf[s] : 0) + (q ? gb[s] : 0) + prev + delay[s], truncated to DATA_WIDTH
  - y = (acc << GAIN_K) << GAIN_TS, truncated to DATA_WIDTH
  - register updates: delay[s] <= y; prev <= y
- Output: system_out = zero-extend(prev after last stage) + p, computed in OUT_WIDTH and registered in DONE.
- Latency: accept at cycle T; out_valid at T+NUM_STAGES+1. Throughput is one sample per NUM_STAGES+2 cycles.
- Config: a write in IDLE updates the gain at the next edge. If cfg_we and an accept coincide, the write lands first and the accepted sample uses the new gain. cfg_addr >= NUM_STAGES is ignored.
- flush in IDLE zeroes all delay[] at the next edge; gains are unchanged. If flush and an accept coincide, the flush applies and stage 0 sees delay = 0. flush outside IDLE is ignored.
- Reset mid-RUN: the in-flight sample is discarded, no out_valid is produced, and all state returns to reset values.

Optional Feature:
SDFP_SEQ_SAT_EN
- Defined: acc and the shifted y are computed at full precision (DATA_WIDTH+GAIN_K+GAIN_TS+2 bits) and clamped to 2^DATA_WIDTH-1 on overflow. A sticky sat_flag output is added; it is cleared by reset or flush.
- Undefined: modulo wrap as above, and no sat_flag port.

Test Plan:
1. After reset, sample p=1, q=0 → stage outputs 2, 6, 14; system_out = 15; out_valid exactly 4 cycles after accept.
2. Repeat the same sample → stage outputs 6, 26, 82; system_out = 83.
3. Reset, write gb[1] = 5 in IDLE, then sample p=0, q=1 → stage outputs 2, 14, 30; system_out = 30. A cfg write while busy is ignored and gb[1] reads back as 5.
4. Feed p=1, q=1 repeatedly until stage 2 exceeds 16383 → the value wraps modulo 16384 with no X. Then flush, then sample p=1, q=0 → system_out = 15.
5. Assert reset on the 2nd RUN cycle → no out_valid, in_ready = 1 on the next cycle, and the next p=1, q=0 sample gives 15.
6. With SDFP_SEQ_SAT_EN, drive the case-4 stimulus → stage output holds at 16383 and sat_flag = 1; flush clears sat_flag.
